// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen
// Brief    : Program counter unit. Resolves sequential, branch and jump
//            next-PC values, buffers a redirect while fetch is stalled,
//            traps misaligned targets, supports halt, and counts retired
//            instructions.
// Revision : 1.0 - initial release
// ============================================================================
module pc_gen #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
  parameter int          STEP      = 4,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             nRST,       // active-high synchronous reset
  input  logic             op_valid,
  input  logic [2:0]       pc_op,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  imm,
  input  logic             zero,
  input  logic             alu_neg,
  input  logic             iready,
  input  logic             halt_req,
  output logic [XLEN-1:0]  pc_addr,
  output logic [XLEN-1:0]  pc_link,
  output logic             redirect,
  output logic             misalign_fault,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  localparam logic [XLEN-1:0] c_reset_pc = XLEN'(RESET_VEC);
  localparam logic [XLEN-1:0] c_trap_pc  = XLEN'(TRAP_VEC);
  localparam logic [XLEN-1:0] c_step     = XLEN'(STEP);

  localparam logic [2:0] c_op_beq  = 3'd1;
  localparam logic [2:0] c_op_bne  = 3'd2;
  localparam logic [2:0] c_op_blt  = 3'd3;
  localparam logic [2:0] c_op_bge  = 3'd4;
  localparam logic [2:0] c_op_jal  = 3'd5;
  localparam logic [2:0] c_op_jalr = 3'd6;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t            r_state, w_nxt_state;
  logic [XLEN-1:0]   r_pc, w_nxt_pc;
  logic [XLEN-1:0]   r_pend_pc, w_nxt_pend_pc;
  logic              r_pend_fault, w_nxt_pend_fault;
  logic              r_redirect, w_nxt_redirect;
  logic              r_fault, w_nxt_fault;
  logic [CNT_W-1:0]  r_instret, w_nxt_instret;

  logic              w_taken;
  logic [XLEN-1:0]   w_rs1_sum;
  logic [XLEN-1:0]   w_tgt;
  logic              w_tgt_misaligned;
  logic              w_misalign;
  logic [XLEN-1:0]   w_seq_pc;
  logic [XLEN-1:0]   w_next;

  // Branch/jump taken decode from the execute-stage flags
  always_comb begin
    w_taken = 1'b0;
    case (pc_op)
      c_op_beq:  w_taken = zero;
      c_op_bne:  w_taken = ~zero;
      c_op_blt:  w_taken = alu_neg;
      c_op_bge:  w_taken = ~alu_neg;
      c_op_jal:  w_taken = 1'b1;
      c_op_jalr: w_taken = 1'b1;
      default:   w_taken = 1'b0;
    endcase
  end

  // Target arithmetic wraps modulo 2^XLEN; JALR drops bit0 of its sum
  assign w_rs1_sum = rs1_data + imm;
  assign w_tgt     = (pc_op == c_op_jalr) ? {w_rs1_sum[XLEN-1:1], 1'b0}
                                          : (r_pc + imm);
  assign w_seq_pc  = r_pc + c_step;

  // Alignment test depends on the instruction granule
  generate
    if (STEP == 2) begin : g_step2
      assign w_tgt_misaligned = w_tgt[0];
    end else begin : g_step4
      assign w_tgt_misaligned = |w_tgt[1:0];
    end
  endgenerate

  assign w_misalign = w_taken & w_tgt_misaligned;
  assign w_next     = w_misalign ? c_trap_pc : (w_taken ? w_tgt : w_seq_pc);

  // Next-state and register-update decode for RUN / HOLD / HALT
  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_pc         = r_pc;
    w_nxt_pend_pc    = r_pend_pc;
    w_nxt_pend_fault = r_pend_fault;
    w_nxt_redirect   = 1'b0;
    w_nxt_fault      = 1'b0;
    w_nxt_instret    = r_instret;
    case (r_state)
      ST_RUN: begin
        if (op_valid) begin
          if (iready) begin
            w_nxt_pc       = w_next;
            w_nxt_instret  = r_instret + 1'b1;
            w_nxt_redirect = w_taken & ~w_misalign;
            w_nxt_fault    = w_misalign;
          end else if (w_taken) begin
            // Fetch is stalled: park the redirect until it is accepted
            w_nxt_pend_pc    = w_next;
            w_nxt_pend_fault = w_misalign;
            w_nxt_state      = ST_HOLD;
          end
        end
        // A same-cycle commit above still completes; pending is dropped
        if (halt_req) w_nxt_state = ST_HALT;
      end
      ST_HOLD: begin
        if (iready) begin
          w_nxt_pc       = r_pend_pc;
          w_nxt_instret  = r_instret + 1'b1;
          w_nxt_redirect = ~r_pend_fault;
          w_nxt_fault    = r_pend_fault;
          w_nxt_state    = ST_RUN;
        end
        if (halt_req) w_nxt_state = ST_HALT;
      end
      ST_HALT: begin
        w_nxt_state = ST_HALT;
      end
      default: begin
        w_nxt_state = ST_RUN;
      end
    endcase
  end

  // State register; reset dominates every other event
  always_ff @(posedge clk) begin
    if (nRST) begin
      r_state      <= ST_RUN;
      r_pc         <= c_reset_pc;
      r_pend_pc    <= '0;
      r_pend_fault <= 1'b0;
      r_redirect   <= 1'b0;
      r_fault      <= 1'b0;
      r_instret    <= '0;
    end else begin
      r_state      <= w_nxt_state;
      r_pc         <= w_nxt_pc;
      r_pend_pc    <= w_nxt_pend_pc;
      r_pend_fault <= w_nxt_pend_fault;
      r_redirect   <= w_nxt_redirect;
      r_fault      <= w_nxt_fault;
      r_instret    <= w_nxt_instret;
    end
  end

  assign pc_addr        = r_pc;
  assign pc_link        = r_pc + c_step;
  assign redirect       = r_redirect;
  assign misalign_fault = r_fault;
  assign halted         = (r_state == ST_HALT);
  assign instret        = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_gen
// Brief    : Self-checking bench for pc_gen: directed scenarios plus a
//            randomized run against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        nRST;
  logic        op_valid;
  logic [2:0]  pc_op;
  logic [31:0] rs1_data;
  logic [31:0] imm;
  logic        zero;
  logic        alu_neg;
  logic        iready;
  logic        halt_req;
  logic [31:0] pc_addr, pc_link;
  logic        redirect, misalign_fault, halted;
  logic [31:0] instret;
  logic [31:0] pc_addr4, pc_link4;
  logic        redirect4, misalign_fault4, halted4;
  logic [3:0]  instret4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_gen u_dut (
    .clk(clk), .nRST(nRST), .op_valid(op_valid), .pc_op(pc_op),
    .rs1_data(rs1_data), .imm(imm), .zero(zero), .alu_neg(alu_neg),
    .iready(iready), .halt_req(halt_req), .pc_addr(pc_addr),
    .pc_link(pc_link), .redirect(redirect), .misalign_fault(misalign_fault),
    .halted(halted), .instret(instret)
  );

  // Narrow-counter instance sharing the same stimulus
  pc_gen #(.CNT_W(4)) u_dut4 (
    .clk(clk), .nRST(nRST), .op_valid(op_valid), .pc_op(pc_op),
    .rs1_data(rs1_data), .imm(imm), .zero(zero), .alu_neg(alu_neg),
    .iready(iready), .halt_req(halt_req), .pc_addr(pc_addr4),
    .pc_link(pc_link4), .redirect(redirect4), .misalign_fault(misalign_fault4),
    .halted(halted4), .instret(instret4)
  );

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instret;
  bit          m_waiting;
  logic [31:0] m_pend;
  bit          m_pend_fault;
  bit          m_halted;
  bit          m_redir;
  bit          m_fault;

  function automatic bit is_taken(logic [2:0] op, logic z, logic n);
    if (op == 3'd1) return z;
    if (op == 3'd2) return !z;
    if (op == 3'd3) return n;
    if (op == 3'd4) return !n;
    return (op == 3'd5) || (op == 3'd6);
  endfunction

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_step();
    logic [31:0] tgt, nxt;
    bit tk, mis;
    m_redir = 0;
    m_fault = 0;
    if (nRST) begin
      m_pc = 32'h0; m_instret = 0; m_waiting = 0; m_halted = 0;
      return;
    end
    if (m_halted) return;
    if (m_waiting) begin
      if (iready) begin
        m_pc = m_pend; m_instret++; m_waiting = 0;
        m_redir = !m_pend_fault; m_fault = m_pend_fault;
      end
    end else if (op_valid) begin
      tk  = is_taken(pc_op, zero, alu_neg);
      tgt = (pc_op == 3'd6) ? ((rs1_data + imm) & 32'hFFFF_FFFE) : (m_pc + imm);
      mis = tk && (tgt % 4 != 0);
      nxt = mis ? 32'h100 : (tk ? tgt : m_pc + 4);
      if (iready) begin
        m_pc = nxt; m_instret++; m_redir = tk && !mis; m_fault = mis;
      end else if (tk) begin
        m_waiting = 1; m_pend = nxt; m_pend_fault = mis;
      end
    end
    if (halt_req) begin
      m_halted = 1; m_waiting = 0;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, logic [2:0] op, logic [31:0] r, logic [31:0] i,
                       bit z, bit n, bit rdy, bit h);
    op_valid = v; pc_op = op; rs1_data = r; imm = i;
    zero = z; alu_neg = n; iready = rdy; halt_req = h; nRST = 0;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    nRST = 1;
    cycle(); cycle();
    checks++; if (pc_addr !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc_addr, 32'h0); end
    checks++; if (instret !== 32'h0) begin errors++; $display("FAIL reset_instret got %h exp %h", instret, 32'h0); end
    checks++; if (halted !== 1'b0 || redirect !== 1'b0 || misalign_fault !== 1'b0) begin
      errors++; $display("FAIL reset_flags got %b%b%b exp 000", halted, redirect, misalign_fault); end
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 3; k++) begin
      cycle();
      checks++; if (pc_addr !== 32'(4 * k)) begin errors++; $display("FAIL seq_pc%0d got %h exp %h", k, pc_addr, 32'(4 * k)); end
    end
    checks++; if (instret !== 32'd3) begin errors++; $display("FAIL seq_instret got %0d exp 3", instret); end
  endtask

  task automatic test_branch();
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    cycle();                                   // pc 0x10
    drive(1, 3'd1, 0, 32'hFFFF_FFF8, 1, 0, 1, 0);
    cycle();
    checks++; if (pc_addr !== 32'h8) begin errors++; $display("FAIL beq_taken_pc got %h exp %h", pc_addr, 32'h8); end
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL beq_redirect got %b exp 1", redirect); end
    drive(1, 3'd5, 0, 32'h8, 0, 0, 1, 0);      // JAL back to 0x10
    cycle();
    drive(1, 3'd1, 0, 32'hFFFF_FFF8, 0, 0, 1, 0);
    cycle();
    checks++; if (pc_addr !== 32'h14) begin errors++; $display("FAIL beq_not_taken_pc got %h exp %h", pc_addr, 32'h14); end
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL beq_no_redirect got %b exp 0", redirect); end
  endtask

  task automatic test_jalr();
    drive(1, 3'd6, 32'h2001, 32'h4, 0, 0, 1, 0);
    #1;
    checks++; if (pc_link !== 32'h18) begin errors++; $display("FAIL jalr_link got %h exp %h", pc_link, 32'h18); end
    cycle();
    checks++; if (pc_addr !== 32'h2004) begin errors++; $display("FAIL jalr_pc got %h exp %h", pc_addr, 32'h2004); end
    drive(1, 3'd6, 32'h2002, 32'h0, 0, 0, 1, 0);
    cycle();
    checks++; if (pc_addr !== 32'h100) begin errors++; $display("FAIL jalr_trap_pc got %h exp %h", pc_addr, 32'h100); end
    checks++; if (misalign_fault !== 1'b1 || redirect !== 1'b0) begin
      errors++; $display("FAIL jalr_fault got f=%b r=%b exp f=1 r=0", misalign_fault, redirect); end
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    cycle();
    checks++; if (misalign_fault !== 1'b0) begin errors++; $display("FAIL fault_one_cycle got %b exp 0", misalign_fault); end
  endtask

  task automatic test_stall();
    logic [31:0] n0;
    drive(1, 3'd5, 0, 32'hFFFF_FF20, 0, 0, 1, 0);   // 0x100 -> 0x20
    cycle();
    n0 = instret;
    drive(1, 3'd5, 0, 32'h40, 0, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    drive(1, 3'd5, 0, 32'h400, 0, 0, 0, 0);         // must not overwrite pending
    cycle();
    checks++; if (pc_addr !== 32'h20) begin errors++; $display("FAIL stall_pc got %h exp %h", pc_addr, 32'h20); end
    checks++; if (instret !== n0) begin errors++; $display("FAIL stall_instret got %0d exp %0d", instret, n0); end
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    cycle();
    checks++; if (pc_addr !== 32'h60) begin errors++; $display("FAIL hold_commit_pc got %h exp %h", pc_addr, 32'h60); end
    checks++; if (instret !== n0 + 1) begin errors++; $display("FAIL hold_commit_instret got %0d exp %0d", instret, n0 + 1); end
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL hold_redirect got %b exp 1", redirect); end
  endtask

  task automatic test_halt();
    drive(1, 3'd5, 0, 32'h40, 0, 0, 0, 0);
    cycle();                                         // HOLD with pending 0xA0
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    cycle();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag got %b exp 1", halted); end
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    cycle(); cycle();
    checks++; if (pc_addr !== 32'h60) begin errors++; $display("FAIL halt_frozen_pc got %h exp %h", pc_addr, 32'h60); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    nRST = 1;
    cycle();
    checks++; if (pc_addr !== 32'h0 || halted !== 1'b0) begin
      errors++; $display("FAIL halt_reset got pc=%h h=%b exp pc=0 h=0", pc_addr, halted); end
  endtask

  task automatic test_wrap();
    drive(1, 3'd5, 0, 32'hFFFF_FFFC, 0, 0, 1, 0);
    cycle();
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    cycle();
    checks++; if (pc_addr !== 32'h0) begin errors++; $display("FAIL pc_wrap got %h exp %h", pc_addr, 32'h0); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    nRST = 1;
    cycle();
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 17; k++) cycle();
    checks++; if (instret4 !== 4'd1) begin errors++; $display("FAIL cnt4_wrap got %0d exp 1", instret4); end
    checks++; if (instret !== 32'd17) begin errors++; $display("FAIL cnt32_17 got %0d exp 17", instret); end
  endtask

  task automatic test_random();
    logic [31:0] r_imm;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    nRST = 1;
    cycle();
    for (int k = 0; k < 400; k++) begin
      r_imm = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 31)) : $urandom;
      r_imm[0] = 1'b0;
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom, r_imm,
            1'($urandom), 1'($urandom), $urandom_range(0, 2) != 0,
            $urandom_range(0, 59) == 0);
      nRST = ($urandom_range(0, 49) == 0);
      cycle();
      checks++; if (pc_addr !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d] got %h exp %h", k, pc_addr, m_pc); end
      checks++; if (pc_link !== m_pc + 32'd4) begin errors++; $display("FAIL rnd_link[%0d] got %h exp %h", k, pc_link, m_pc + 32'd4); end
      checks++; if (redirect !== m_redir) begin errors++; $display("FAIL rnd_redirect[%0d] got %b exp %b", k, redirect, m_redir); end
      checks++; if (misalign_fault !== m_fault) begin errors++; $display("FAIL rnd_fault[%0d] got %b exp %b", k, misalign_fault, m_fault); end
      checks++; if (halted !== m_halted) begin errors++; $display("FAIL rnd_halted[%0d] got %b exp %b", k, halted, m_halted); end
      checks++; if (instret !== m_instret) begin errors++; $display("FAIL rnd_instret[%0d] got %0d exp %0d", k, instret, m_instret); end
      checks++; if (instret4 !== m_instret[3:0]) begin errors++; $display("FAIL rnd_instret4[%0d] got %0d exp %0d", k, instret4, m_instret[3:0]); end
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jalr();
    test_stall();
    test_halt();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
